// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C command sequencer
//
// Purpose: FSM state encoding, command field widths, packed command word
//          width helper and controller mode constants.
// Ports:   none (package).
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_RESP   = 3'd3,
    ST_GAP    = 3'd4
  } seq_state_t;

  localparam int MODE_W = 2;
  localparam int ADDR_W = 7;
  localparam int REG_W  = 8;
  localparam int RW_W   = 1;

  localparam logic [MODE_W-1:0] MODE_STANDARD   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_FAST       = 2'd1;
  localparam logic [MODE_W-1:0] MODE_FAST_PLUS  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_HIGH_SPEED = 2'd3;

  // Packed command word layout, MSB first: {mode, addr, reg, rw, data}
  function automatic int cmd_word_w(input int data_w);
    return MODE_W + ADDR_W + REG_W + RW_W + data_w;
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// rtl/i2c_cmd_fifo.sv - synchronous command FIFO with occupancy count
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of two) with combinational head
//          read; full/empty are derived from the registered occupancy only.
// Ports:   clk, rst (sync active-high), push/wdata, pop/rdata,
//          full, empty, level.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == FULL_LVL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - buffers I2C commands and sequences them into i2c_controller
//
// Purpose: accepts commands on a valid/ready port into i2c_cmd_fifo, launches
//          each on the controller's ctrl_* inputs, waits for busy to rise and
//          fall, and returns one response per command in order.
// Optional: define I2C_SEQ_TIMEOUT_EN for a per-phase watchdog that completes
//           the command with rsp_err=1 after TIMEOUT_CYCLES in LAUNCH or RUN.
// Ports:   clk, rst (sync active-high)
//          cmd_valid/cmd_ready/cmd_mode/cmd_addr/cmd_reg/cmd_rw/cmd_wdata
//          rsp_valid/rsp_ready/rsp_rdata/rsp_rw/rsp_err
//          ctrl_en/ctrl_mode/ctrl_slave_address/ctrl_target_register/
//          ctrl_rw/ctrl_din (to controller), ctrl_dout/ctrl_busy (from it)
//          level (FIFO occupancy), idle (FIFO empty and FSM in IDLE)
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_reg,
  input  logic                     cmd_rw,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_rw,
  output logic                     rsp_err,
  output logic                     ctrl_en,
  output logic [1:0]               ctrl_mode,
  output logic [6:0]               ctrl_slave_address,
  output logic [7:0]               ctrl_target_register,
  output logic                     ctrl_rw,
  output logic [DATA_W-1:0]        ctrl_din,
  input  logic [DATA_W-1:0]        ctrl_dout,
  input  logic                     ctrl_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int CMD_W    = cmd_word_w(DATA_W);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  seq_state_t        r_state;
  logic              r_ctrl_en;
  logic [1:0]        r_ctrl_mode;
  logic [6:0]        r_ctrl_addr;
  logic [7:0]        r_ctrl_reg;
  logic              r_ctrl_rw;
  logic [DATA_W-1:0] r_ctrl_din;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_rw;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic [CMD_W-1:0]  w_cmd_word;
  logic [CMD_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  assign w_cmd_word = {cmd_mode, cmd_addr, cmd_reg, cmd_rw, cmd_wdata};

  // A launch needs a queued command and a controller that is not still busy
  assign w_pop = (r_state == ST_IDLE) && !w_empty && !ctrl_busy;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (w_cmd_word),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign cmd_ready            = !w_full;
  assign idle                 = w_empty && (r_state == ST_IDLE);
  assign ctrl_en              = r_ctrl_en;
  assign ctrl_mode            = r_ctrl_mode;
  assign ctrl_slave_address   = r_ctrl_addr;
  assign ctrl_target_register = r_ctrl_reg;
  assign ctrl_rw              = r_ctrl_rw;
  assign ctrl_din             = r_ctrl_din;
  assign rsp_valid            = r_rsp_valid;
  assign rsp_rdata            = r_rsp_rdata;
  assign rsp_rw               = r_rsp_rw;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ctrl_en   <= 1'b0;
      r_ctrl_mode <= '0;
      r_ctrl_addr <= '0;
      r_ctrl_reg  <= '0;
      r_ctrl_rw   <= 1'b0;
      r_ctrl_din  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_rw    <= 1'b0;
      r_gap_cnt   <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_ctrl_mode <= w_head[CMD_W-1 -: MODE_W];
            r_ctrl_addr <= w_head[DATA_W+RW_W+REG_W +: ADDR_W];
            r_ctrl_reg  <= w_head[DATA_W+RW_W +: REG_W];
            r_ctrl_rw   <= w_head[DATA_W];
            r_ctrl_din  <= w_head[DATA_W-1:0];
            r_ctrl_en   <= 1'b1;
            r_state     <= ST_LAUNCH;
`ifdef I2C_SEQ_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end

        ST_LAUNCH: begin
`ifdef I2C_SEQ_TIMEOUT_EN
          r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
          if (ctrl_busy) begin
            r_state <= ST_RUN;
`ifdef I2C_SEQ_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_ctrl_en   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_rw    <= r_ctrl_rw;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`endif
        end

        ST_RUN: begin
`ifdef I2C_SEQ_TIMEOUT_EN
          r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
          if (!ctrl_busy) begin
            r_ctrl_en   <= 1'b0;
            r_rsp_rdata <= r_ctrl_rw ? ctrl_dout : '0;
            r_rsp_rw    <= r_ctrl_rw;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef I2C_SEQ_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_ctrl_en   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_rw    <= r_ctrl_rw;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`endif
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_gap_cnt   <= '0;
            r_state     <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - directed self-checking bench for i2c_cmd_sequencer
module tb_i2c_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = '0;
  logic [6:0]  cmd_addr = '0;
  logic [7:0]  cmd_reg = '0;
  logic        cmd_rw = 1'b0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        rsp_rw;
  logic        rsp_err;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic [6:0]  ctrl_slave_address;
  logic [7:0]  ctrl_target_register;
  logic        ctrl_rw;
  logic [15:0] ctrl_din;
  logic [15:0] ctrl_dout = '0;
  logic        ctrl_busy = 1'b0;
  logic [2:0]  level;
  logic        idle;

  int checks = 0;
  int errors = 0;

  // Behavioural controller knobs
  int          busy_len = 10;
  bit          stuck = 1'b0;
  bit          no_busy = 1'b0;
  bit          dout_sel = 1'b0;
  logic [15:0] model_dout = '0;
  logic        m_wait = 1'b0;
  int          m_cnt = 0;

  // Response log
  logic [15:0] q_rdata[$];
  logic        q_rw[$];
  logic        q_err[$];
  int          rsp_cnt = 0;

  i2c_cmd_sequencer #(
    .DEPTH(4), .DATA_W(16), .GAP_CYCLES(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rw(rsp_rw), .rsp_err(rsp_err),
    .ctrl_en(ctrl_en), .ctrl_mode(ctrl_mode), .ctrl_slave_address(ctrl_slave_address),
    .ctrl_target_register(ctrl_target_register), .ctrl_rw(ctrl_rw), .ctrl_din(ctrl_din),
    .ctrl_dout(ctrl_dout), .ctrl_busy(ctrl_busy), .level(level), .idle(idle)
  );

  always #5 clk = ~clk;

  // Controller model: raise busy one cycle after en, hold for busy_len cycles,
  // present dout as busy falls, then wait for en to drop before re-arming.
  always @(posedge clk) begin
    if (rst) begin
      ctrl_busy <= 1'b0;
      m_wait    <= 1'b0;
      m_cnt     <= 0;
      ctrl_dout <= '0;
    end else if (ctrl_busy) begin
      if (!stuck) begin
        if (m_cnt <= 1) begin
          ctrl_busy <= 1'b0;
          m_wait    <= 1'b1;
          ctrl_dout <= dout_sel ? {8'hC0, ctrl_target_register} : model_dout;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if (m_wait) begin
      if (!ctrl_en) m_wait <= 1'b0;
    end else if (ctrl_en && !no_busy) begin
      ctrl_busy <= 1'b1;
      m_cnt     <= busy_len;
    end
  end

  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      q_rdata.push_back(rsp_rdata);
      q_rw.push_back(rsp_rw);
      q_err.push_back(rsp_err);
      rsp_cnt = rsp_cnt + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_cmd(input logic [1:0] m, input logic [6:0] a, input logic [7:0] r,
                          input logic rw, input logic [15:0] d);
    int n = 0;
    cmd_mode = m; cmd_addr = a; cmd_reg = r; cmd_rw = rw; cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_wait got cmd_ready=%0b exp 1", cmd_ready);
    end else begin
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    int n = 0;
    while (rsp_cnt < target && n < 5000) begin @(negedge clk); n++; end
    ok = (rsp_cnt >= target);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (!idle && n < 5000) begin @(negedge clk); n++; end
    ok = idle;
  endtask

  task automatic wait_en(output bit ok);
    int n = 0;
    while (!ctrl_en && n < 200) begin @(negedge clk); n++; end
    ok = ctrl_en;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL rst_ctrl_en got %b exp 0", ctrl_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({rsp_rdata, rsp_rw, rsp_err} !== 18'd0) begin errors++; $display("FAIL rst_rsp_fields got %h exp 0", {rsp_rdata, rsp_rw, rsp_err}); end
    checks++; if ({ctrl_mode, ctrl_slave_address, ctrl_target_register, ctrl_rw, ctrl_din} !== 34'd0) begin
      errors++; $display("FAIL rst_ctrl_fields got %h exp 0", {ctrl_mode, ctrl_slave_address, ctrl_target_register, ctrl_rw, ctrl_din});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    int base;
    bit ok, seen, en_ok;
    base = rsp_cnt;
    dout_sel = 1'b0; model_dout = 16'h1234; busy_len = 200; rsp_ready = 1'b1;
    push_cmd(2'd1, 7'h49, 8'h96, 1'b1, 16'hAACC);
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_launch got ctrl_en=%b exp 1", ctrl_en); end
    checks++; if (ctrl_slave_address !== 7'h49) begin errors++; $display("FAIL rd_addr got %h exp 49", ctrl_slave_address); end
    checks++; if (ctrl_target_register !== 8'h96) begin errors++; $display("FAIL rd_reg got %h exp 96", ctrl_target_register); end
    checks++; if (ctrl_mode !== 2'd1 || ctrl_rw !== 1'b1) begin errors++; $display("FAIL rd_mode_rw got %0d/%b exp 1/1", ctrl_mode, ctrl_rw); end
    seen = 1'b0; en_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!ctrl_en) en_ok = 1'b0;
      if (ctrl_busy) seen = 1'b1;
      if (seen && !ctrl_busy) break;
      @(negedge clk);
    end
    checks++; if (!(seen && en_ok)) begin errors++; $display("FAIL rd_en_hold got seen=%b held=%b exp 1/1", seen, en_ok); end
    wait_rsp(base + 1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rd_rsp got count=%0d exp %0d", rsp_cnt, base + 1);
    end else if (q_rdata[base] !== 16'h1234 || q_rw[base] !== 1'b1 || q_err[base] !== 1'b0) begin
      errors++; $display("FAIL rd_rsp got %h/%b/%b exp 1234/1/0", q_rdata[base], q_rw[base], q_err[base]);
    end
    wait_idle(ok);
    checks++; if (!ok || rsp_cnt != base + 1) begin errors++; $display("FAIL rd_one_rsp got idle=%b count=%0d exp 1/%0d", ok, rsp_cnt, base + 1); end
  endtask

  task automatic test_write;
    int base;
    bit ok;
    base = rsp_cnt;
    dout_sel = 1'b0; model_dout = 16'hBEEF; busy_len = 20; rsp_ready = 1'b1;
    push_cmd(2'd1, 7'h49, 8'h96, 1'b0, 16'hAACC);
    wait_en(ok);
    checks++; if (!ok || ctrl_din !== 16'hAACC || ctrl_rw !== 1'b0) begin
      errors++; $display("FAIL wr_ctrl got en=%b din=%h rw=%b exp 1/aacc/0", ok, ctrl_din, ctrl_rw);
    end
    wait_rsp(base + 1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wr_rsp got count=%0d exp %0d", rsp_cnt, base + 1);
    end else if (q_rdata[base] !== 16'h0000 || q_rw[base] !== 1'b0) begin
      errors++; $display("FAIL wr_rsp got %h/%b exp 0000/0", q_rdata[base], q_rw[base]);
    end
    wait_idle(ok);
  endtask

  task automatic test_fill_backpressure;
    int base;
    bit ok;
    base = rsp_cnt;
    dout_sel = 1'b1; busy_len = 3; stuck = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(2'd0, 7'h22, 8'h10 + 8'(i), 1'b1, 16'h0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d exp 4", level); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", cmd_ready); end
    stuck = 1'b0;
    wait_rsp(base + 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_count got %0d exp %0d", rsp_cnt, base + 5); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q_rdata[base+i] !== 16'hC010 + 16'(i)) begin
          errors++; $display("FAIL fill_order[%0d] got %h exp %h", i, q_rdata[base+i], 16'hC010 + 16'(i));
        end
      end
    end
    wait_idle(ok);
    checks++; if (!ok || cmd_ready !== 1'b1 || level !== 3'd0) begin
      errors++; $display("FAIL fill_drain got idle=%b ready=%b level=%0d exp 1/1/0", ok, cmd_ready, level);
    end
  endtask

  task automatic test_rsp_stall;
    int base, n, bad;
    bit ok;
    base = rsp_cnt;
    dout_sel = 1'b1; busy_len = 5; rsp_ready = 1'b0;
    push_cmd(2'd2, 7'h30, 8'h21, 1'b1, 16'h0);
    push_cmd(2'd2, 7'h30, 8'h22, 1'b1, 16'h0);
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", rsp_valid); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hC021 || rsp_rw !== 1'b1 || ctrl_en !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL stall_level got %0d exp 1", level); end
    rsp_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (ctrl_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_low got %0d high cycles exp 0", bad); end
    @(negedge clk);
    checks++; if (ctrl_en !== 1'b1) begin errors++; $display("FAIL gap_end got ctrl_en=%b exp 1", ctrl_en); end
    wait_rsp(base + 2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_count got %0d exp %0d", rsp_cnt, base + 2);
    end else if (q_rdata[base] !== 16'hC021 || q_rdata[base+1] !== 16'hC022) begin
      errors++; $display("FAIL stall_order got %h,%h exp c021,c022", q_rdata[base], q_rdata[base+1]);
    end
    wait_idle(ok);
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int bad;
    bit ok;
    no_busy = 1'b1; rsp_ready = 1'b0;
    push_cmd(2'd3, 7'h11, 8'h44, 1'b1, 16'h0);
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_launch got ctrl_en=%b exp 1", ctrl_en); end
    bad = 0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_early got %0d early cycles exp 0", bad); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0 || ctrl_en !== 1'b0) begin
      errors++; $display("FAIL to_expire got v=%b err=%b d=%h en=%b exp 1/1/0000/0", rsp_valid, rsp_err, rsp_rdata, ctrl_en);
    end
    rsp_ready = 1'b1; no_busy = 1'b0;
    wait_idle(ok);
  endtask
`endif

  task automatic test_reset_mid_run;
    int base, n;
    bit ok;
    dout_sel = 1'b0; model_dout = 16'h5555; busy_len = 200; rsp_ready = 1'b1;
    push_cmd(2'd0, 7'h0A, 8'h33, 1'b1, 16'h0);
    push_cmd(2'd0, 7'h0A, 8'h34, 1'b0, 16'h7777);
    n = 0;
    while (!ctrl_busy && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (ctrl_en !== 1'b1 || level !== 3'd1) begin
      errors++; $display("FAIL mid_pre got en=%b level=%0d exp 1/1", ctrl_en, level);
    end
    base = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL mid_en got %b exp 0", ctrl_en); end
    checks++; if (level !== 3'd0 || idle !== 1'b1) begin errors++; $display("FAIL mid_flush got level=%0d idle=%b exp 0/1", level, idle); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
    repeat (300) @(negedge clk);
    checks++; if (rsp_cnt != base || ctrl_en !== 1'b0) begin
      errors++; $display("FAIL mid_no_rsp got count=%0d en=%b exp %0d/0", rsp_cnt, ctrl_en, base);
    end
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fill_backpressure();
    test_rsp_stall();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
